bridge_pio_read_arbiter: RTL and testbench

- Two-requester round-robin read arbiter in front of the PIO input slave (s1 port: 2-bit address, 32-bit readdata, registered one-cycle read latency).
- Shares the PIO between the HPS-side bridge master (m0) and a local fabric master (m1).
- Sequences issue, tracks in-flight reads through the slave's fixed latency, and routes returned data back to the owning requester with readdatavalid.

---
 rtl/bridge_pio_pkg.sv | 17 +
 rtl/bridge_pio_rr_arb2.sv | 33 +++
 rtl/bridge_pio_read_arbiter.sv | 103 ++++++++++
 tb/tb_bridge_pio_read_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_pio_pkg.sv
// Shared definitions for the PIO read arbiter slice:
// requester IDs, in-flight entry type and default widths.
package bridge_pio_pkg;

    localparam int DEF_ADDR_W = 2;
    localparam int DEF_DATA_W = 32;

    localparam logic REQ_M0 = 1'b0;
    localparam logic REQ_M1 = 1'b1;

    // One slot of the read-latency pipeline.
    typedef struct packed {
        logic valid;
        logic owner;
    } inflight_t;

endpackage

// File: rtl/bridge_pio_rr_arb2.sv
// Two-way round-robin arbiter: combinational grants,
// pointer flips to the other requester on every grant.
module bridge_pio_rr_arb2
    import bridge_pio_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    logic ptr;

    // Grant the requester the pointer prefers; none while in reset.
    always_comb begin
        gnt0 = !reset && req0 && (!req1 || ptr == REQ_M0);
        gnt1 = !reset && req1 && (!req0 || ptr == REQ_M1);
    end

    // Hand priority to the other side after each grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= REQ_M0;
        end else if (gnt0) begin
            ptr <= REQ_M1;
        end else if (gnt1) begin
            ptr <= REQ_M0;
        end
    end

endmodule

// File: rtl/bridge_pio_read_arbiter.sv
// Round-robin read arbiter sharing the PIO slave between two
// masters, with fixed-latency return routing back to the owner.
module bridge_pio_read_arbiter
    import bridge_pio_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] s_address,
    output logic              s_read,
    input  logic [DATA_W-1:0] s_readdata
);

    logic grant_m0;
    logic grant_m1;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] rd0_q;
    logic [DATA_W-1:0] rd1_q;
    inflight_t [READ_LATENCY-1:0] pipe;
    inflight_t last;

    bridge_pio_rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req0  (m0_read),
        .req1  (m1_read),
        .gnt0  (grant_m0),
        .gnt1  (grant_m1)
    );

    // Issue the granted address; park on the last one when idle.
    always_comb begin
        s_read         = grant_m0 | grant_m1;
        m0_waitrequest = m0_read & !grant_m0;
        m1_waitrequest = m1_read & !grant_m1;
        if (grant_m0) begin
            s_address = m0_address;
        end else if (grant_m1) begin
            s_address = m1_address;
        end else begin
            s_address = addr_q;
        end
    end

    // Remember the last issued address for idle cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
        end else if (s_read) begin
            addr_q <= s_address;
        end
    end

    // Track each issued read through the slave latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe <= '0;
        end else begin
            pipe[0] <= '{valid: s_read, owner: grant_m1};
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    // Route the returning beat to its owner.
    always_comb begin
        last             = pipe[READ_LATENCY-1];
        m0_readdatavalid = last.valid && last.owner == REQ_M0;
        m1_readdatavalid = last.valid && last.owner == REQ_M1;
        m0_readdata      = m0_readdatavalid ? s_readdata : rd0_q;
        m1_readdata      = m1_readdatavalid ? s_readdata : rd1_q;
    end

    // Hold each requester's last returned word between beats.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd0_q <= '0;
            rd1_q <= '0;
        end else begin
            if (m0_readdatavalid) begin
                rd0_q <= s_readdata;
            end
            if (m1_readdatavalid) begin
                rd1_q <= s_readdata;
            end
        end
    end

endmodule

// File: tb/tb_bridge_pio_read_arbiter.sv
// Directed bench: latency-1 arbiter plus a latency-3 build,
// each in front of a simple PIO slave model.
module tb_bridge_pio_read_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // latency-1 instance
    logic [1:0]  a_m0_addr = '0;
    logic        a_m0_read = 1'b0;
    logic        a_m0_wait;
    logic [31:0] a_m0_rd;
    logic        a_m0_rdv;
    logic [1:0]  a_m1_addr = '0;
    logic        a_m1_read = 1'b0;
    logic        a_m1_wait;
    logic [31:0] a_m1_rd;
    logic        a_m1_rdv;
    logic [1:0]  a_s_addr;
    logic        a_s_read;
    logic [31:0] a_s_rd;
    logic        in_port = 1'b1;

    // latency-3 instance
    logic [1:0]  b_m0_addr = '0;
    logic        b_m0_read = 1'b0;
    logic        b_m0_wait;
    logic [31:0] b_m0_rd;
    logic        b_m0_rdv;
    logic [1:0]  b_m1_addr = '0;
    logic        b_m1_read = 1'b0;
    logic        b_m1_wait;
    logic [31:0] b_m1_rd;
    logic        b_m1_rdv;
    logic [1:0]  b_s_addr;
    logic        b_s_read;
    logic [31:0] b_s_rd;
    logic        in_b = 1'b0;
    logic [31:0] b_r1;
    logic [31:0] b_r2;

    bridge_pio_read_arbiter #(.READ_LATENCY(1)) u1 (
        .clk              (clk),
        .reset            (reset),
        .m0_address       (a_m0_addr),
        .m0_read          (a_m0_read),
        .m0_waitrequest   (a_m0_wait),
        .m0_readdata      (a_m0_rd),
        .m0_readdatavalid (a_m0_rdv),
        .m1_address       (a_m1_addr),
        .m1_read          (a_m1_read),
        .m1_waitrequest   (a_m1_wait),
        .m1_readdata      (a_m1_rd),
        .m1_readdatavalid (a_m1_rdv),
        .s_address        (a_s_addr),
        .s_read           (a_s_read),
        .s_readdata       (a_s_rd)
    );

    bridge_pio_read_arbiter #(.READ_LATENCY(3)) u3 (
        .clk              (clk),
        .reset            (reset),
        .m0_address       (b_m0_addr),
        .m0_read          (b_m0_read),
        .m0_waitrequest   (b_m0_wait),
        .m0_readdata      (b_m0_rd),
        .m0_readdatavalid (b_m0_rdv),
        .m1_address       (b_m1_addr),
        .m1_read          (b_m1_read),
        .m1_waitrequest   (b_m1_wait),
        .m1_readdata      (b_m1_rd),
        .m1_readdatavalid (b_m1_rdv),
        .s_address        (b_s_addr),
        .s_read           (b_s_read),
        .s_readdata       (b_s_rd)
    );

    // PIO slave models: address 0 returns in_port in bit 0.
    always @(posedge clk) begin
        a_s_rd <= (a_s_addr == 2'd0) ? {31'b0, in_port} : 32'b0;
        b_r1   <= (b_s_addr == 2'd0) ? {31'b0, in_b} : 32'b0;
        b_r2   <= b_r1;
        b_s_rd <= b_r2;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int m0v;
    int m1v;
    int w0;
    int w1;
    int maxw;
    logic [31:0] e3 [4];
    logic [1:0]  a3 [4];
    logic        i3 [4];

    initial begin
        e3 = '{32'd1, 32'd0, 32'd0, 32'd1};
        a3 = '{2'd0, 2'd1, 2'd0, 2'd0};
        i3 = '{1'b1, 1'b0, 1'b0, 1'b1};

        // reset with both requesting
        a_m0_read = 1'b1;
        a_m1_read = 1'b1;
        tick();
        tick();
        #3;
        chk("rst_m0_wait", 32'(a_m0_wait), 32'd1);
        chk("rst_m1_wait", 32'(a_m1_wait), 32'd1);
        chk("rst_s_read", 32'(a_s_read), 32'd0);
        chk("rst_s_addr", 32'(a_s_addr), 32'd0);
        chk("rst_m0_rdv", 32'(a_m0_rdv), 32'd0);
        chk("rst_m1_rdv", 32'(a_m1_rdv), 32'd0);
        chk("rst_m0_rd", a_m0_rd, 32'd0);
        chk("rst_m1_rd", a_m1_rd, 32'd0);

        // same-cycle contention right after reset
        tick();
        reset = 1'b0;
        #3;
        chk("con0_m0_wait", 32'(a_m0_wait), 32'd0);
        chk("con0_m1_wait", 32'(a_m1_wait), 32'd1);
        chk("con0_s_read", 32'(a_s_read), 32'd1);
        tick();
        a_m0_read = 1'b0;
        #3;
        chk("con1_m1_wait", 32'(a_m1_wait), 32'd0);
        chk("con1_m0_rdv", 32'(a_m0_rdv), 32'd1);
        chk("con1_m0_rd", a_m0_rd, 32'd1);
        chk("con1_m1_rdv", 32'(a_m1_rdv), 32'd0);
        tick();
        a_m1_read = 1'b0;
        #3;
        chk("con2_m1_rdv", 32'(a_m1_rdv), 32'd1);
        chk("con2_m1_rd", a_m1_rd, 32'd1);
        chk("con2_m0_rdv", 32'(a_m0_rdv), 32'd0);

        // lone m0 read of address 0
        tick();
        a_m0_read = 1'b1;
        a_m0_addr = 2'd0;
        #3;
        chk("lone_m0_wait", 32'(a_m0_wait), 32'd0);
        tick();
        a_m0_read = 1'b0;
        #3;
        chk("lone_m0_rdv", 32'(a_m0_rdv), 32'd1);
        chk("lone_m0_rd", a_m0_rd, 32'd1);
        chk("lone_m1_rdv", 32'(a_m1_rdv), 32'd0);

        // m1 reads address 2: data 0, m0 data held
        tick();
        a_m1_read = 1'b1;
        a_m1_addr = 2'd2;
        #3;
        chk("a2_m1_wait", 32'(a_m1_wait), 32'd0);
        chk("a2_s_addr", 32'(a_s_addr), 32'd2);
        tick();
        a_m1_read = 1'b0;
        #3;
        chk("a2_m1_rdv", 32'(a_m1_rdv), 32'd1);
        chk("a2_m1_rd", a_m1_rd, 32'd0);
        chk("a2_m0_hold", a_m0_rd, 32'd1);
        chk("a2_addr_hold", 32'(a_s_addr), 32'd2);
        chk("a2_idle_read", 32'(a_s_read), 32'd0);

        // continuous contention for 8 cycles
        tick();
        m0v = 0;
        m1v = 0;
        w0 = 0;
        w1 = 0;
        maxw = 0;
        a_m0_addr = 2'd0;
        a_m1_addr = 2'd1;
        for (int k = 0; k <= 8; k++) begin
            a_m0_read = (k < 8);
            a_m1_read = (k < 8);
            #3;
            if (k < 8) begin
                chk("rr_m0_wait", 32'(a_m0_wait), 32'(k % 2));
                chk("rr_m1_wait", 32'(a_m1_wait), 32'((k + 1) % 2));
            end
            if (a_m0_rdv) begin
                chk("rr_m0_rd", a_m0_rd, 32'd1);
                m0v++;
            end
            if (a_m1_rdv) begin
                chk("rr_m1_rd", a_m1_rd, 32'd0);
                m1v++;
            end
            w0 = a_m0_wait ? w0 + 1 : 0;
            w1 = a_m1_wait ? w1 + 1 : 0;
            if (w0 > maxw) maxw = w0;
            if (w1 > maxw) maxw = w1;
            tick();
        end
        chk("rr_m0_count", 32'(m0v), 32'd4);
        chk("rr_m1_count", 32'(m1v), 32'd4);
        chk("rr_max_wait", 32'(maxw), 32'd1);

        // m0 grant, then reset in the following cycle
        a_m0_read = 1'b1;
        a_m0_addr = 2'd0;
        #3;
        chk("mid_m0_wait", 32'(a_m0_wait), 32'd0);
        tick();
        a_m0_read = 1'b0;
        reset = 1'b1;
        #3;
        chk("mid_rst_rdv", 32'(a_m0_rdv), 32'd0);
        chk("mid_rst_rd", a_m0_rd, 32'd0);
        tick();
        reset = 1'b0;
        #3;
        chk("mid_post_rdv", 32'(a_m0_rdv), 32'd0);
        tick();
        a_m0_read = 1'b1;
        a_m1_read = 1'b1;
        #3;
        chk("mid_ptr_m0", 32'(a_m0_wait), 32'd0);
        chk("mid_ptr_m1", 32'(a_m1_wait), 32'd1);
        tick();
        a_m0_read = 1'b0;
        #3;
        chk("mid_m1_next", 32'(a_m1_wait), 32'd0);
        tick();
        a_m1_read = 1'b0;

        // latency-3 build: back-to-back m0 reads at cycles 0..3
        for (int c = 0; c < 8; c++) begin
            b_m0_read = (c < 4);
            if (c < 4) begin
                b_m0_addr = a3[c];
                in_b = i3[c];
            end
            #3;
            if (c < 4) chk("l3_wait", 32'(b_m0_wait), 32'd0);
            chk("l3_rdv", 32'(b_m0_rdv), 32'(c >= 3 && c <= 6));
            chk("l3_m1_rdv", 32'(b_m1_rdv), 32'd0);
            if (c >= 3 && c <= 6) chk("l3_rd", b_m0_rd, e3[c-3]);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
